// File: rtl/sumador_serial_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two MedioSumador + OR) is
// reused across all N bit positions, one bit per clock, with start/done handshake.

module MedioSumador (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module sumador_serial_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Suma,
  output logic         Cout,
  output logic         ocupado,
  output logic         listo
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    LISTO   = 2'd2
  } estado_t;

  estado_t        r_state;
  estado_t        w_next;
  logic [N-1:0]   r_regA;
  logic [N-1:0]   r_regB;
  logic [N-1:0]   r_res;
  logic [N-1:0]   r_suma;
  logic [CW-1:0]  r_cnt;
  logic           r_carry;
  logic           r_cout;
  logic           r_ocupado;
  logic           r_listo;

  logic           w_s0;
  logic           w_c0;
  logic           w_s;
  logic           w_c1;
  logic           w_cout;
  logic           w_last;
  logic [N-1:0]   w_resNext;

  // Shared full-adder cell: the only adder on the data path.
  MedioSumador u_ms0 (.i_a(r_regA[0]), .i_b(r_regB[0]), .o_s(w_s0), .o_c(w_c0));
  MedioSumador u_ms1 (.i_a(w_s0),      .i_b(r_carry),   .o_s(w_s),  .o_c(w_c1));
  assign w_cout = w_c0 | w_c1;

  assign w_last    = (r_cnt == LAST);
  assign w_resNext = (r_res >> 1) | (N'(w_s) << (N - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= REPOSO;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      REPOSO:  if (inicio) w_next = SUMANDO;
      SUMANDO: if (w_last) w_next = LISTO;
      LISTO:   w_next = REPOSO;
      default: w_next = REPOSO;
    endcase
  end

  // Operands shift out LSB-first; result bits enter at the MSB so the word is
  // correctly aligned after exactly N shifts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regA    <= '0;
      r_regB    <= '0;
      r_res     <= '0;
      r_suma    <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
    end else begin
      r_ocupado <= (w_next != REPOSO);
      r_listo   <= (w_next == LISTO);
      case (r_state)
        REPOSO: begin
          if (inicio) begin
            r_regA  <= A;
            r_regB  <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        SUMANDO: begin
          r_regA  <= r_regA >> 1;
          r_regB  <= r_regB >> 1;
          r_carry <= w_cout;
          r_res   <= w_resNext;
          if (w_last) begin
            r_suma <= w_resNext;
            r_cout <= w_cout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Suma    = r_suma;
  assign Cout    = r_cout;
  assign ocupado = r_ocupado;
  assign listo   = r_listo;
endmodule
